gsm_larc_decode: RTL

- Downstream neighbour of the LPC analysis stage.
- Reads the 8 quantised log-area-ratio codes (LARc[0..7]) that the analysis stage writes, and decodes them to LARpp[0..7].
- Follows the GSM 06.10 "decoding of coded LAR" arithmetic: offset by MIC, remove B, scale by INVA, then double.
- Uses the same ap_start/ap_done/ap_idle/ap_ready block protocol and single-port memory interfaces as the rest of the LPC chain. Its output feeds the LARp interpolation / short-term filter stage.

---
 rtl/gsm_lpc_pkg.sv | 43 ++++
 rtl/gsm_lar_dec_dp.sv | 63 ++++++
 rtl/gsm_larc_decode.sv | 88 ++++++++
 3 files changed

// File: rtl/gsm_lpc_pkg.sv
// gsm_lpc_pkg: shared LPC-chain types, LAR decode constant tables and GSM saturating arithmetic.
// Contents:
//   N_LAR, DATA_W   frame geometry
//   s16_t, state_t  signed 16-bit sample type and block-protocol FSM states
//   MIC, B, INVA    per-coefficient decode constants indexed by the 3-bit LAR number
//   sat16, gsm_add, gsm_sub, gsm_mult_r  pure arithmetic helpers
package gsm_lpc_pkg;
    localparam int N_LAR  = 8;
    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] s16_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam s16_t MIC [N_LAR] = '{
        -16'sd32, -16'sd32, -16'sd16, -16'sd16, -16'sd8, -16'sd8, -16'sd4, -16'sd4
    };
    localparam s16_t B [N_LAR] = '{
        16'sd0, 16'sd0, 16'sd2048, -16'sd2560, 16'sd94, -16'sd1792, -16'sd341, -16'sd1144
    };
    localparam s16_t INVA [N_LAR] = '{
        16'sd13107, 16'sd13107, 16'sd13107, 16'sd13107, 16'sd19223, 16'sd17476, 16'sd31454, 16'sd29708
    };

    function automatic s16_t sat16(input logic signed [31:0] x);
        return (x > 32'sd32767) ? 16'sh7FFF : (x < -32'sd32768) ? 16'sh8000 : x[15:0];
    endfunction

    function automatic s16_t gsm_add(input s16_t a, input s16_t b);
        return sat16(32'(a) + 32'(b));
    endfunction

    function automatic s16_t gsm_sub(input s16_t a, input s16_t b);
        return sat16(32'(a) - 32'(b));
    endfunction

    // Rounded Q15 product; arithmetic shift floors negative values.
    // The -32768 * -32768 corner cannot occur here because INVA is always positive.
    function automatic s16_t gsm_mult_r(input s16_t a, input s16_t b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b) + 32'sd16384;
        return p[30:15];
    endfunction
endpackage

// File: rtl/gsm_lar_dec_dp.sv
// gsm_lar_dec_dp: two-stage LARc -> LARpp decode datapath with valid/index sidebands.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rd_v, i_rd_idx    read strobe/index as issued to the LARc memory
//   i_q                 LARc read data, valid the cycle after the read strobe
//   o_wr_v, o_wr_idx    LARpp write strobe and index (index forced to 0 when idle)
//   o_wr_d              decoded LARpp value (forced to 0 when idle)
//   o_last              the write of the final coefficient is on the port this cycle
module gsm_lar_dec_dp
    import gsm_lpc_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd_v,
    input  logic [2:0]  i_rd_idx,
    input  logic [15:0] i_q,
    output logic        o_wr_v,
    output logic [2:0]  o_wr_idx,
    output logic [15:0] o_wr_d,
    output logic        o_last
);
    logic               r_rd_v;
    logic [2:0]         r_rd_idx;
    logic               r_v1;
    logic [2:0]         r_idx1;
    s16_t               r_t1;
    s16_t               w_a;
    logic signed [31:0] w_t;
    s16_t               w_m;
    s16_t               w_pp;

    // Stage 1 works on q in the cycle it is valid; the sideband delays the
    // read strobe/index by one cycle so they line up with q.
    always_comb begin
        w_a  = gsm_add($signed(i_q), MIC[r_rd_idx]);
        w_t  = (32'(w_a) <<< 10) - (32'(B[r_rd_idx]) <<< 1);
        w_m  = gsm_mult_r(INVA[r_idx1], r_t1);
        w_pp = gsm_add(w_m, w_m);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_v   <= 1'b0;
            r_rd_idx <= '0;
            r_v1     <= 1'b0;
            r_idx1   <= '0;
            r_t1     <= '0;
        end else begin
            r_rd_v   <= i_rd_v;
            r_rd_idx <= i_rd_idx;
            r_v1     <= r_rd_v;
            r_idx1   <= r_rd_idx;
            r_t1     <= sat16(w_t);
        end
    end

    // Stage 2 is combinational from the stage-1 registers so the write lands
    // one cycle after q; outputs are gated to keep the port quiet when idle.
    assign o_wr_v   = r_v1;
    assign o_wr_idx = r_v1 ? r_idx1 : 3'd0;
    assign o_wr_d   = r_v1 ? w_pp : 16'd0;
    assign o_last   = r_v1 && (r_idx1 == 3'(N_LAR - 1));
endmodule

// File: rtl/gsm_larc_decode.sv
// gsm_larc_decode: decodes the 8 LARc codes of a frame into LARpp using the ap_* block protocol.
// Ports:
//   ap_clk, ap_rst                 clock, synchronous active-high reset
//   ap_start/done/idle/ready       block handshake; done and ready pulse together
//   LARc_address0/ce0/q0           single-port read of the coded LARs
//   LARpp_address0/ce0/we0/d0      single-port write of the decoded LARs
module gsm_larc_decode
    import gsm_lpc_pkg::*;
(
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [2:0]  LARc_address0,
    output logic        LARc_ce0,
    input  logic [15:0] LARc_q0,
    output logic [2:0]  LARpp_address0,
    output logic        LARpp_ce0,
    output logic        LARpp_we0,
    output logic [15:0] LARpp_d0
);
    state_t     r_state;
    logic       r_idle;
    logic       r_done;
    logic       r_ce;
    logic [2:0] r_addr;
    logic       w_wr_v;
    logic       w_last;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
            r_done  <= 1'b0;
            r_ce    <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: if (ap_start) begin
                    r_state <= RUN;
                    r_idle  <= 1'b0;
                    r_ce    <= 1'b1;
                    r_addr  <= '0;
                end
                RUN: if (r_addr == 3'(N_LAR - 1)) begin
                    r_state <= DRAIN;
                    r_ce    <= 1'b0;
                    r_addr  <= '0;
                end else begin
                    r_addr  <= r_addr + 3'd1;
                end
                // Wait for the final write to be on the port, then pulse done.
                DRAIN: if (w_last) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    gsm_lar_dec_dp u_dp (
        .i_clk    (ap_clk),
        .i_rst    (ap_rst),
        .i_rd_v   (r_ce),
        .i_rd_idx (r_addr),
        .i_q      (LARc_q0),
        .o_wr_v   (w_wr_v),
        .o_wr_idx (LARpp_address0),
        .o_wr_d   (LARpp_d0),
        .o_last   (w_last)
    );

    assign ap_done       = r_done;
    assign ap_ready      = r_done;
    assign ap_idle       = r_idle;
    assign LARc_ce0      = r_ce;
    assign LARc_address0 = r_addr;
    assign LARpp_ce0     = w_wr_v;
    assign LARpp_we0     = w_wr_v;
endmodule
